// File: rtl/fetch_src_if.sv
// fetch_src_if: bundle between the fetch-source controller and its
// requesters / fetch mux.
//   slave  : controller side (takes requests, drives mux strobes and pulses)
//   master : requester / fetch-PC side
// Signals:
//   stall_i, ic_hit, irq_req, mc_req, mc_entry, mc_len   -> controller
//   en, mc_en, hwi, mc_rom_addr, pc_hold,
//   irq_ack, mc_ack, mc_done, busy                       <- controller
interface fetch_src_if #(
  parameter int MC_AWID = 10,
  parameter int MC_LWID = 4
);
  logic               stall_i;
  logic               ic_hit;
  logic               irq_req;
  logic               mc_req;
  logic [MC_AWID-1:0] mc_entry;
  logic [MC_LWID-1:0] mc_len;
  logic               en;
  logic               mc_en;
  logic               hwi;
  logic [MC_AWID-1:0] mc_rom_addr;
  logic               pc_hold;
  logic               irq_ack;
  logic               mc_ack;
  logic               mc_done;
  logic               busy;

  modport master (
    output stall_i, ic_hit, irq_req, mc_req, mc_entry, mc_len,
    input  en, mc_en, hwi, mc_rom_addr, pc_hold, irq_ack, mc_ack, mc_done, busy
  );

  modport slave (
    input  stall_i, ic_hit, irq_req, mc_req, mc_entry, mc_len,
    output en, mc_en, hwi, mc_rom_addr, pc_hold, irq_ack, mc_ack, mc_done, busy
  );
endinterface

// File: rtl/fetch_src_ctrl.sv
// fetch_src_ctrl: selects the fetch-stage instruction source among cache
// line, hardware-interrupt instruction and micro-code ROM.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-low
//   bus  - fetch_src_if.slave (requests in; mux strobes, pc_hold, pulses out)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_FETCH | normal fetch from cache; arbitrates irq_req > mc_req > fetch
// ST_HWI   | issue interrupt instruction for one unstalled cycle
// ST_MC    | issue micro-code groups until count reaches zero (atomic)
module fetch_src_ctrl #(
  parameter int MC_AWID = 10,
  parameter int MC_LWID = 4
) (
  input logic        clk,
  input logic        rst,
  fetch_src_if.slave bus
);

  // One extra bit so a length of 0 can hold 2**MC_LWID groups.
  localparam int CW = MC_LWID + 1;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HWI   = 2'd1,
    ST_MC    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [MC_AWID-1:0] addr_q, addr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               irq_ack_q, irq_ack_d;
  logic               mc_ack_q, mc_ack_d;
  logic               mc_done_q, mc_done_d;

  logic en_c, mc_en_c, hwi_c, pc_hold_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_FETCH;
      addr_q    <= '0;
      count_q   <= '0;
      irq_ack_q <= 1'b0;
      mc_ack_q  <= 1'b0;
      mc_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      irq_ack_q <= irq_ack_d;
      mc_ack_q  <= mc_ack_d;
      mc_done_q <= mc_done_d;
    end
  end

  // Next state and datapath. A stall leaves every register at its value and
  // suppresses new pulses.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    irq_ack_d = 1'b0;
    mc_ack_d  = 1'b0;
    mc_done_d = 1'b0;
    if (!bus.stall_i) begin
      case (state_q)
        ST_FETCH: begin
          if (bus.irq_req) begin
            irq_ack_d = 1'b1;
            state_d   = ST_HWI;
          end else if (bus.mc_req) begin
            mc_ack_d = 1'b1;
            addr_d   = bus.mc_entry;
            count_d  = (bus.mc_len == '0) ? {1'b1, {MC_LWID{1'b0}}}
                                           : {1'b0, bus.mc_len};
            state_d  = ST_MC;
          end
        end
        ST_HWI: state_d = ST_FETCH;
        ST_MC: begin
          addr_d  = addr_q + MC_AWID'(1);
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            mc_done_d = 1'b1;
            state_d   = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // Mux strobes; all held low while reset is asserted.
  always_comb begin
    en_c      = 1'b0;
    mc_en_c   = 1'b0;
    hwi_c     = 1'b0;
    pc_hold_c = 1'b0;
    if (rst) begin
      if (bus.stall_i) begin
        pc_hold_c = 1'b1;
      end else begin
        case (state_q)
          ST_FETCH: begin
            if (bus.irq_req || bus.mc_req) begin
              pc_hold_c = 1'b1;
            end else begin
              en_c      = bus.ic_hit;
              pc_hold_c = ~bus.ic_hit;
            end
          end
          ST_HWI: begin
            hwi_c     = 1'b1;
            pc_hold_c = 1'b1;
          end
          ST_MC: begin
            mc_en_c   = 1'b1;
            pc_hold_c = 1'b1;
          end
          default: pc_hold_c = 1'b1;
        endcase
      end
    end
  end

  assign bus.en          = en_c;
  assign bus.mc_en       = mc_en_c;
  assign bus.hwi         = hwi_c;
  assign bus.pc_hold     = pc_hold_c;
  assign bus.mc_rom_addr = addr_q;
  assign bus.irq_ack     = irq_ack_q;
  assign bus.mc_ack      = mc_ack_q;
  assign bus.mc_done     = mc_done_q;
  assign bus.busy        = (state_q != ST_FETCH);

endmodule

// File: doc/fetch_src_ctrl.md
Name: fetch_src_ctrl

Overview:
Controller that sequences the fetch-stage instruction multiplexer between its three sources: cache line, hardware-interrupt instruction and micro-code ROM. It arbitrates interrupt and micro-code requests against normal fetch, steps the micro-code ROM address, and drives the mux select strobes (en, mc_en, hwi) plus a PC-hold to the fetch PC logic. It sits between the interrupt/micro-code requesters and the fetch mux, ahead of decode.

Parameters:
MC_AWID, 10, micro-code ROM address width (bits).
MC_LWID, 4, width of mc_len; a length of 0 means 2**MC_LWID groups.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  synchronous reset, active-low.
stall_i  in  1  downstream not accepting this cycle; freezes controller.
ic_hit  in  1  cache line at fetch is valid.
irq_req  in  1  interrupt request level; held until irq_ack.
mc_req  in  1  micro-code sequence request; held until mc_ack.
mc_entry  in  MC_AWID  micro-code entry address, sampled with mc_ack.
mc_len  in  MC_LWID  number of 4-instruction groups to issue.
en  out  1  select cache-line source this cycle.
mc_en  out  1  select micro-code source this cycle.
hwi  out  1  select interrupt instruction this cycle.
mc_rom_addr  out  MC_AWID  micro-code ROM group address.
pc_hold  out  1  fetch PC must not advance this cycle.
irq_ack  out  1  one-cycle pulse: interrupt accepted.
mc_ack  out  1  one-cycle pulse: micro-code request accepted.
mc_done  out  1  one-cycle pulse: last micro-code group issued.
busy  out  1  state is not FETCH.

Behaviour:
- States: FETCH, HWI, MC. Reset (rst==0 at clock edge) -> FETCH, mc_rom_addr=0, count=0. Registered outputs (irq_ack, mc_ack, mc_done) clear; combinational strobes are 0 while rst==0.
- Reset mid-sequence: immediate return to FETCH; partially issued micro-code is abandoned, no mc_done; unacked requests stay pending at requester.
- stall_i==1: no state, counter or address change; en/mc_en/hwi forced 0; pc_hold=1; no ack/done pulses.
- FETCH, stall_i==0, priority irq_req > mc_req > fetch:
  - irq_req: irq_ack=1 next cycle, next state HWI; en=0, pc_hold=1.
  - else mc_req: mc_ack=1 next cycle; mc_rom_addr<=mc_entry; count<=mc_len (0 -> 2**MC_LWID); next state MC; en=0, pc_hold=1.
  - else: en=ic_hit, pc_hold=~ic_hit.
- HWI: hwi=1 and pc_hold=1 for exactly one unstalled cycle, then FETCH. Interrupt-to-hwi latency: 1 unstalled cycle after acceptance.
- MC: mc_en=1, pc_hold=1 each unstalled cycle; mc_rom_addr+=1 (wraps modulo 2**MC_AWID), count-=1. When count==1 on an unstalled cycle: mc_done=1 next cycle, next state FETCH. irq_req and mc_req are ignored in MC (micro-code sequence is atomic); a pending irq is taken on the first unstalled FETCH cycle after.
- irq_req and mc_req together in FETCH: irq wins; mc_req accepted on the first unstalled FETCH cycle after HWI.
- en, mc_en, hwi are mutually exclusive (one-hot-or-zero) every cycle.
- busy = (state != FETCH).

Test Plan:
- Reset: hold rst=0 3 cycles with irq_req=1 -> all outputs 0; no irq_ack; after release, irq_ack asserts 1 cycle later.
- Plain fetch: ic_hit=1, no requests, 10 cycles -> en=1 and pc_hold=0 every cycle; ic_hit=0 -> en=0, pc_hold=1.
- Micro-code: mc_entry=0x3FE, mc_len=3 -> mc_ack pulse; mc_en for 3 cycles with addresses 0x3FE, 0x3FF, 0x000 (wrap); mc_done next cycle; back to FETCH. mc_len=0 -> 16 groups.
- Collision: irq_req and mc_req asserted together -> HWI one cycle (hwi=1), then MC sequence; irq_req asserted during MC -> taken only after mc_done.
- Stall: stall_i=1 for 4 cycles mid-MC (mc_len=4, after 2nd group) -> address/count frozen, mc_en=0; sequence resumes and completes 4 groups total.
- Reset mid-MC after 1 of 5 groups -> FETCH next cycle, no mc_done, mc_rom_addr=0.
